// File: rtl/ysyx_23060251_axi_pkg.sv
// Shared AXI-lite response codes and request-FSM state encoding for axi_master.
package ysyx_23060251_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RESP
  } axi_state_e;

  // States in which the master is waiting on the slave.
  function automatic logic is_bus_wait(axi_state_e s);
    return (s == ST_RD_ADDR) || (s == ST_RD_DATA) || (s == ST_WR_REQ) || (s == ST_WR_RESP);
  endfunction

endpackage

// File: rtl/axi_mst_watchdog.sv
// Bus-wait cycle counter for axi_master; only instantiated when
// YSYX_23060251_AXI_TIMEOUT_EN is defined.
module axi_mst_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_en,
  input  logic i_clear,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en)    r_cnt <= r_cnt + CNT_W'(1);
  end

  // Fires on the last waiting cycle so the FSM leaves after exactly TIMEOUT_CYC cycles.
  assign o_timeout = i_en && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/axi_master.sv
// Single-outstanding request-to-AXI-lite master with registered outputs.
// Optional bus watchdog enabled by defining YSYX_23060251_AXI_TIMEOUT_EN.
module axi_master
  import ysyx_23060251_axi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                mst_ar_valid_o,
  output logic [ADDR_W-1:0]   mst_ar_addr_o,
  input  logic                mst_ar_ready_i,
  input  logic                mst_r_valid_i,
  input  logic [DATA_W-1:0]   mst_r_data_i,
  input  logic [1:0]          mst_r_resp_i,
  output logic                mst_r_ready_o,
  output logic                mst_aw_valid_o,
  output logic [ADDR_W-1:0]   mst_aw_addr_o,
  input  logic                mst_aw_ready_i,
  output logic                mst_w_valid_o,
  output logic [DATA_W-1:0]   mst_w_data_o,
  output logic [DATA_W/8-1:0] mst_w_strb_o,
  input  logic                mst_w_ready_i,
  input  logic                mst_b_valid_i,
  input  logic [1:0]          mst_b_resp_i,
  output logic                mst_b_ready_o
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("axi_master: TIMEOUT_CYC must be at least 1");
  end

  axi_state_e        r_state, w_state_n;
  logic              r_req_ready, r_ar_valid, r_r_ready, r_aw_valid, r_w_valid, r_b_ready;
  logic              r_rsp_valid, r_rsp_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              w_accept, w_aw_done, w_w_done, w_timeout;

  assign w_accept  = r_req_ready && req_valid_i;
  assign w_aw_done = !r_aw_valid || mst_aw_ready_i;
  assign w_w_done  = !r_w_valid  || mst_w_ready_i;

`ifdef YSYX_23060251_AXI_TIMEOUT_EN
  logic w_busy, w_state_change;
  assign w_busy         = is_bus_wait(r_state);
  assign w_state_change = (w_state_n != r_state);

  axi_mst_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_en      (w_busy),
    .i_clear   (w_state_change),
    .o_timeout (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: next state gets its default first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_n = req_we_i ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: if (mst_ar_ready_i) w_state_n = ST_RD_DATA;
      ST_RD_DATA: if (mst_r_valid_i) w_state_n = ST_RESP;
      ST_WR_REQ:  if (w_aw_done && w_w_done) w_state_n = ST_WR_RESP;
      ST_WR_RESP: if (mst_b_valid_i) w_state_n = ST_RESP;
      ST_RESP:    if (r_rsp_valid && rsp_ready_i) w_state_n = ST_IDLE;
      default:    w_state_n = ST_IDLE;
    endcase
    if (w_timeout) w_state_n = ST_RESP;
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_ar_valid  <= 1'b0;
      r_r_ready   <= 1'b0;
      r_aw_valid  <= 1'b0;
      r_w_valid   <= 1'b0;
      r_b_ready   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_req_ready <= (w_state_n == ST_IDLE);
      r_ar_valid  <= (w_state_n == ST_RD_ADDR);
      r_r_ready   <= (w_state_n == ST_RD_DATA);
      // AW and W rise together on entry, then each clears on its own handshake.
      r_aw_valid  <= (w_state_n == ST_WR_REQ) &&
                     ((r_state != ST_WR_REQ) || (r_aw_valid && !mst_aw_ready_i));
      r_w_valid   <= (w_state_n == ST_WR_REQ) &&
                     ((r_state != ST_WR_REQ) || (r_w_valid && !mst_w_ready_i));
      r_b_ready   <= (w_state_n == ST_WR_RESP);
      r_rsp_valid <= (r_state == ST_RESP) && (w_state_n == ST_RESP);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_wstrb <= req_wstrb_i;
      end
      if (w_timeout) begin
        r_rdata   <= '0;
        r_rsp_err <= 1'b1;
      end else if ((r_state == ST_RD_DATA) && mst_r_valid_i) begin
        r_rdata   <= mst_r_data_i;
        r_rsp_err <= (mst_r_resp_i != RESP_OKAY);
      end else if ((r_state == ST_WR_RESP) && mst_b_valid_i) begin
        r_rdata   <= '0;
        r_rsp_err <= (mst_b_resp_i != RESP_OKAY);
      end
    end
  end

  assign req_ready_o    = r_req_ready;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_rdata_o    = r_rdata;
  assign rsp_err_o      = r_rsp_err;
  assign mst_ar_valid_o = r_ar_valid;
  assign mst_ar_addr_o  = r_addr;
  assign mst_r_ready_o  = r_r_ready;
  assign mst_aw_valid_o = r_aw_valid;
  assign mst_aw_addr_o  = r_addr;
  assign mst_w_valid_o  = r_w_valid;
  assign mst_w_data_o   = r_wdata;
  assign mst_w_strb_o   = r_wstrb;
  assign mst_b_ready_o  = r_b_ready;

endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master: vector table of single transactions plus
// hand-written handshake, stall, reset and watchdog sequences.
module tb_axi_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mst_ar_valid_o, mst_ar_ready_i, mst_r_valid_i, mst_r_ready_o;
  logic [31:0] mst_ar_addr_o, mst_r_data_i;
  logic [1:0]  mst_r_resp_i;
  logic        mst_aw_valid_o, mst_aw_ready_i, mst_w_valid_o, mst_w_ready_i;
  logic [31:0] mst_aw_addr_o, mst_w_data_o;
  logic [3:0]  mst_w_strb_o;
  logic        mst_b_valid_i, mst_b_ready_o;
  logic [1:0]  mst_b_resp_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i),
    .mst_r_ready_o(mst_r_ready_o),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o),
    .mst_w_ready_i(mst_w_ready_i),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_resp_i(mst_b_resp_i), .mst_b_ready_o(mst_b_ready_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic slave_idle();
    mst_ar_ready_i = 1'b0; mst_aw_ready_i = 1'b0; mst_w_ready_i = 1'b0;
    mst_r_valid_i  = 1'b0; mst_r_data_i   = '0;   mst_r_resp_i  = 2'b00;
    mst_b_valid_i  = 1'b0; mst_b_resp_i   = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready_o,    1);
    check({tag, "_rsp_valid"}, rsp_valid_o,    0);
    check({tag, "_rsp_rdata"}, rsp_rdata_o,    0);
    check({tag, "_rsp_err"},   rsp_err_o,      0);
    check({tag, "_ar_valid"},  mst_ar_valid_o, 0);
    check({tag, "_ar_addr"},   mst_ar_addr_o,  0);
    check({tag, "_r_ready"},   mst_r_ready_o,  0);
    check({tag, "_aw_valid"},  mst_aw_valid_o, 0);
    check({tag, "_aw_addr"},   mst_aw_addr_o,  0);
    check({tag, "_w_valid"},   mst_w_valid_o,  0);
    check({tag, "_w_data"},    mst_w_data_o,   0);
    check({tag, "_w_strb"},    mst_w_strb_o,   0);
    check({tag, "_b_ready"},   mst_b_ready_o,  0);
  endtask

  // Waits for rsp_valid_o; returns cycles waited, or the bound on expiry.
  task automatic wait_rsp(input int bound, output int lat);
    lat = 0;
    while (!rsp_valid_o && lat < bound) begin
      tick();
      lat++;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_wstrb_i = wstrb;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    lat;
    string p;
    p = $sformatf("v%0d", idx);
    // Slave is always ready/valid; the master must only consume what its state expects.
    mst_ar_ready_i = 1'b1; mst_aw_ready_i = 1'b1; mst_w_ready_i = 1'b1;
    mst_r_valid_i  = 1'b1; mst_r_data_i   = v.s_data; mst_r_resp_i = v.s_resp;
    mst_b_valid_i  = 1'b1; mst_b_resp_i   = v.s_resp;
    issue(v.we, v.addr, v.wdata, v.wstrb);
    check({p, "_req_ready_busy"}, req_ready_o, 0);
    if (v.we) begin
      check({p, "_aw_valid"}, mst_aw_valid_o, 1);
      check({p, "_w_valid"},  mst_w_valid_o,  1);
      check({p, "_aw_addr"},  mst_aw_addr_o,  v.addr);
      check({p, "_w_data"},   mst_w_data_o,   v.wdata);
      check({p, "_w_strb"},   mst_w_strb_o,   v.wstrb);
      check({p, "_ar_valid"}, mst_ar_valid_o, 0);
    end else begin
      check({p, "_ar_valid"}, mst_ar_valid_o, 1);
      check({p, "_ar_addr"},  mst_ar_addr_o,  v.addr);
      check({p, "_aw_valid"}, mst_aw_valid_o, 0);
    end
    wait_rsp(20, lat);
    check({p, "_latency"}, lat, 3);
    check({p, "_rdata"},   rsp_rdata_o, v.exp_rdata);
    check({p, "_err"},     rsp_err_o,   v.exp_err);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check({p, "_rsp_done"},  rsp_valid_o, 0);
    check({p, "_req_ready"}, req_ready_o, 1);
    slave_idle();
  endtask

  initial begin
    int  lat;
    logic seen;

    //           we    addr          wdata         strb  s_data        resp   exp_rdata     err
    vecs[0] = '{1'b0, 32'h1000_0000, 32'h0,        4'h0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 32'h2000_0004, 32'h0,        4'h0, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1'b1};
    vecs[2] = '{1'b0, 32'h2000_0008, 32'h0,        4'h0, 32'h0000_1234, 2'b11, 32'h0000_1234, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 32'h8000_0001, 2'b01, 32'h8000_0001, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, 32'h5555_5555, 2'b00, 32'h0,         1'b0};
    vecs[5] = '{1'b1, 32'h8000_0020, 32'hA5A5_0F0F, 4'h3, 32'h7777_7777, 2'b10, 32'h0,         1'b1};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h8, 32'h0,         2'b11, 32'h0,         1'b1};

    rst_i = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    rsp_ready_i = 1'b0;
    slave_idle();
    repeat (2) tick();
    check_reset_outputs("por");
    rst_i = 1'b1;
    tick();
    check("por_idle_ready", req_ready_o, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // W accepted two cycles before AW; one B response.
    issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
    check("wr_split_aw_up", mst_aw_valid_o, 1);
    check("wr_split_w_up",  mst_w_valid_o,  1);
    mst_w_ready_i = 1'b1;
    tick();
    mst_w_ready_i = 1'b0;
    check("wr_split_w_drop",  mst_w_valid_o,  0);
    check("wr_split_aw_hold", mst_aw_valid_o, 1);
    check("wr_split_b_wait",  mst_b_ready_o,  0);
    tick();
    check("wr_split_aw_hold2", mst_aw_valid_o, 1);
    check("wr_split_aw_addr",  mst_aw_addr_o,  32'h8000_0010);
    mst_aw_ready_i = 1'b1;
    tick();
    mst_aw_ready_i = 1'b0;
    check("wr_split_aw_drop", mst_aw_valid_o, 0);
    check("wr_split_b_ready", mst_b_ready_o,  1);
    mst_b_valid_i = 1'b1;
    mst_b_resp_i  = 2'b00;
    tick();
    check("wr_split_b_single", mst_b_ready_o, 0);
    wait_rsp(5, lat);
    check("wr_split_b_ready_resp", mst_b_ready_o, 0);
    check("wr_split_rsp_valid", rsp_valid_o, 1);
    check("wr_split_err",   rsp_err_o,   0);
    check("wr_split_rdata", rsp_rdata_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    slave_idle();

    // Response held 5 cycles with a competing request.
    mst_ar_ready_i = 1'b1; mst_r_valid_i = 1'b1; mst_r_data_i = 32'hA5A5_5A5A; mst_r_resp_i = 2'b10;
    issue(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    wait_rsp(20, lat);
    check("stall_latency", lat, 3);
    slave_idle();
    req_we_i = 1'b1; req_addr_i = 32'h9000_0000; req_wdata_i = 32'h1111_2222; req_wstrb_i = 4'hF;
    req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall%0d_rsp_valid", c), rsp_valid_o,    1);
      check($sformatf("stall%0d_rdata", c),     rsp_rdata_o,    32'hA5A5_5A5A);
      check($sformatf("stall%0d_err", c),       rsp_err_o,      1);
      check($sformatf("stall%0d_req_ready", c), req_ready_o,    0);
      check($sformatf("stall%0d_aw_valid", c),  mst_aw_valid_o, 0);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("stall_rsp_done", rsp_valid_o, 0);
    check("stall_req_ready", req_ready_o, 1);

    // Asynchronous reset while waiting for R data.
    mst_ar_ready_i = 1'b1;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'h0);
    tick();
    check("rst_mid_in_rd_data", mst_r_ready_o, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    slave_idle();
    mst_r_valid_i = 1'b1; mst_r_data_i = 32'h0BAD_0BAD;
    repeat (2) tick();
    rst_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid_o || mst_r_ready_o) seen = 1'b1;
    end
    check("rst_mid_no_response", seen, 0);
    check("rst_mid_idle", req_ready_o, 1);
    slave_idle();

    // ARREADY stuck low.
    issue(1'b0, 32'h5000_0000, 32'h0, 4'h0);
`ifdef YSYX_23060251_AXI_TIMEOUT_EN
    repeat (15) tick();
    check("to_ar_valid_before", mst_ar_valid_o, 1);
    tick();
    check("to_ar_valid_drop", mst_ar_valid_o, 0);
    check("to_r_ready",       mst_r_ready_o,  0);
    wait_rsp(5, lat);
    check("to_rsp_valid", rsp_valid_o, 1);
    check("to_err",       rsp_err_o,   1);
    check("to_rdata",     rsp_rdata_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("to_back_idle", req_ready_o, 1);
`else
    repeat (40) tick();
    check("no_to_ar_valid", mst_ar_valid_o, 1);
    check("no_to_rsp_valid", rsp_valid_o, 0);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
